// File: rtl/pipe_mem_stage.sv
// pipe_mem_stage: memory-access stage between execute and write-back.
// Takes one EX result per valid/ready handshake and issues byte, half, word or
// dword accesses on a req/gnt/rvalid port. Load data comes back lane-aligned
// and sign- or zero-extended. Misaligned ops complete without a memory access.
// The stage also feeds forwarding and load-hazard information back to decode.
module pipe_mem_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,  // 32 or 64
  parameter int IDX_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  // execute-stage side
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [1:0]          ex_op,
  input  logic [1:0]          ex_len,
  input  logic [ADDR_W-1:0]   ex_ans,
  input  logic [DATA_W-1:0]   ex_din,
  input  logic                ex_wb_e,
  input  logic [IDX_W-1:0]    ex_wb_idx,
  // memory port
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  // write-back side
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic                wb_e,
  output logic [IDX_W-1:0]    wb_idx,
  output logic [DATA_W-1:0]   wb_out,
  output logic                wb_misalign,
  // forwarding / hazard
  output logic [IDX_W-1:0]    fwd_idx,
  output logic [DATA_W-1:0]   fwd_val,
  output logic                ld_pend,
  output logic [IDX_W-1:0]    ld_pend_idx
);

  localparam int LANES = DATA_W / 8;
  localparam int OFS_W = $clog2(LANES);

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ST   = 2'b01;
  localparam logic [1:0] OP_LDS  = 2'b10;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_OUT    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [1:0]          len_q, len_d;
  logic [OFS_W-1:0]    ofs_q, ofs_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LANES-1:0]    be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wb_e_q, wb_e_d;
  logic [IDX_W-1:0]    wb_idx_q, wb_idx_d;
  logic [DATA_W-1:0]   wb_out_q, wb_out_d;
  logic                mis_q, mis_d;

  // ---------------------------------------------------------------------------
  // Decode of the op being offered by EX (used only on the accepting cycle)
  // ---------------------------------------------------------------------------
  logic                accept;
  logic [OFS_W-1:0]    acc_ofs;
  logic                acc_mis;
  logic [LANES-1:0]    acc_mask;
  logic [LANES-1:0]    acc_be;
  logic [DATA_W-1:0]   acc_wdata;
  logic [DATA_W-1:0]   ans_ext;

  assign ex_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && wb_ready);
  assign accept   = ex_valid && ex_ready;
  assign acc_ofs  = ex_ans[OFS_W-1:0];
  assign ans_ext  = DATA_W'(ex_ans);

  // Alignment rule per access length; dword is illegal on a 32-bit datapath
  always_comb begin
    acc_mis = 1'b0;
    case (ex_len)
      LEN_B:   acc_mis = 1'b0;
      LEN_H:   acc_mis = acc_ofs[0];
      LEN_W:   acc_mis = (acc_ofs[1:0] != 2'b00);
      default: acc_mis = (DATA_W == 32) ? 1'b1 : (acc_ofs != '0);
    endcase
  end

  // Contiguous byte mask of the access size, before shifting to the offset
  always_comb begin
    acc_mask = '1;
    case (ex_len)
      LEN_B:   acc_mask = LANES'(4'b0001);
      LEN_H:   acc_mask = LANES'(4'b0011);
      LEN_W:   acc_mask = LANES'(4'b1111);
      default: acc_mask = '1;
    endcase
  end

  assign acc_be = acc_mask << acc_ofs;

  // Store data is replicated across the bus so every lane the byte enables
  // select already holds the right byte, regardless of offset.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign acc_wdata[8*gi +: 8] =
      (ex_len == LEN_B) ? ex_din[7:0] :
      (ex_len == LEN_H) ? ex_din[8*(gi%2) +: 8] :
      (ex_len == LEN_W) ? ex_din[8*(gi%4) +: 8] :
                          ex_din[8*gi +: 8];
  end

  // ---------------------------------------------------------------------------
  // Load data alignment and extension
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] rd_keep;
  logic              rd_sign;
  logic [DATA_W-1:0] ld_data;

  assign rd_shift = mem_rdata >> {ofs_q, 3'b000};

  // Width mask and sign bit of the loaded value
  always_comb begin
    rd_keep = '1;
    rd_sign = 1'b0;
    case (len_q)
      LEN_B: begin
        rd_keep = DATA_W'(8'hFF);
        rd_sign = rd_shift[7];
      end
      LEN_H: begin
        rd_keep = DATA_W'(16'hFFFF);
        rd_sign = rd_shift[15];
      end
      LEN_W: begin
        rd_keep = DATA_W'(32'hFFFF_FFFF);
        rd_sign = rd_shift[31];
      end
      default: begin
        rd_keep = '1;
        rd_sign = 1'b0;
      end
    endcase
  end

  assign ld_data = (rd_shift & rd_keep) |
                   (((op_q == OP_LDS) && rd_sign) ? ~rd_keep : '0);

  // ---------------------------------------------------------------------------
  // Next-state logic: handshake sequencing and payload capture
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    len_d    = len_q;
    ofs_d    = ofs_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    wb_e_d   = wb_e_q;
    wb_idx_d = wb_idx_q;
    wb_out_d = wb_out_q;
    mis_d    = mis_q;

    case (state_q)
      S_IDLE: ;
      S_REQ: begin
        if (mem_gnt) begin
          state_d = (op_q == OP_ST) ? S_OUT : S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (mem_rvalid) begin
          wb_out_d = ld_data;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (wb_ready && !ex_valid) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new op may be taken from IDLE or straight out of OUT
    if (accept) begin
      op_d     = ex_op;
      len_d    = ex_len;
      ofs_d    = acc_ofs;
      addr_d   = {ex_ans[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
      be_d     = acc_be;
      wdata_d  = acc_wdata;
      wb_idx_d = ex_wb_idx;
      wb_out_d = ans_ext;
      mis_d    = 1'b0;
      if (ex_op == OP_NONE) begin
        wb_e_d  = ex_wb_e;
        state_d = S_OUT;
      end else if (acc_mis) begin
        mis_d   = 1'b1;
        wb_e_d  = 1'b0;
        state_d = S_OUT;
      end else begin
        // stores never write back a register
        wb_e_d  = (ex_op == OP_ST) ? 1'b0 : ex_wb_e;
        state_d = S_REQ;
      end
    end
  end

  // State and payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      len_q    <= '0;
      ofs_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      wb_e_q   <= 1'b0;
      wb_idx_q <= '0;
      wb_out_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      len_q    <= len_d;
      ofs_q    <= ofs_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      wb_e_q   <= wb_e_d;
      wb_idx_q <= wb_idx_d;
      wb_out_q <= wb_out_d;
      mis_q    <= mis_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: memory signals live only in REQ, payload only in OUT, so every
  // output is quiet while idle or after reset.
  // ---------------------------------------------------------------------------
  logic in_req;
  logic in_out;

  assign in_req = (state_q == S_REQ);
  assign in_out = (state_q == S_OUT);

  assign mem_req   = in_req;
  assign mem_we    = in_req && (op_q == OP_ST);
  assign mem_addr  = in_req ? addr_q  : '0;
  assign mem_be    = in_req ? be_q    : '0;
  assign mem_wdata = in_req ? wdata_q : '0;

  assign wb_valid    = in_out;
  assign wb_e        = in_out && wb_e_q;
  assign wb_idx      = in_out ? wb_idx_q : '0;
  assign wb_out      = in_out ? wb_out_q : '0;
  assign wb_misalign = in_out && mis_q;

  assign fwd_idx = (wb_valid && wb_e) ? wb_idx : '0;
  assign fwd_val = wb_out;

  // A load is outstanding from the request until its data returns
  assign ld_pend     = ((state_q == S_REQ) || (state_q == S_WAIT_R)) && wb_e_q && op_q[1];
  assign ld_pend_idx = ld_pend ? wb_idx_q : '0;

endmodule
